// File: rtl/radio_chan_map.sv
// radio_chan_map: settings-bus programmed N-channel rx/tx/gpio permutation.
// Maps switch atomically via IDLE->WAIT->BLANK; sticky err/ovr/lock status.
module radio_chan_map #(
  parameter int          NUM_CHANNELS = 2,
  parameter int          DATA_WIDTH   = 32,
  parameter logic [7:0]  SR_BASE      = 8'd0,
  parameter int          BLANK_CYCLES = 2
) (
  input  logic                                radio_clk,
  input  logic                                radio_rst_n,
  input  logic                                set_stb,
  input  logic [7:0]                          set_addr,
  input  logic [31:0]                         set_data,
  output logic [31:0]                         rb_data,
  input  logic [NUM_CHANNELS-1:0]             rx_stb_in,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]  rx_data_in,
  output logic [NUM_CHANNELS-1:0]             rx_stb_out,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0]  rx_data_out,
  input  logic [NUM_CHANNELS-1:0]             tx_stb_in,
  output logic [NUM_CHANNELS-1:0]             tx_stb_out,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]  tx_data_in,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0]  tx_data_out,
  input  logic [NUM_CHANNELS*32-1:0]          db_gpio_in,
  output logic [NUM_CHANNELS*32-1:0]          db_gpio_out,
  input  logic [NUM_CHANNELS-1:0]             rx_running,
  input  logic [NUM_CHANNELS-1:0]             tx_running,
  input  logic [1:0]                          lock_signals,
  output logic                                map_busy
);

  localparam int N  = NUM_CHANNELS;
  localparam int DW = DATA_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BLANK = 2'd2
  } state_e;

  function automatic logic [31:0] ident_map();
    logic [31:0] m;
    m = '0;
    for (int k = 0; k < N; k++) begin
      m[4*k +: 4] = 4'(k);
    end
    return m;
  endfunction

  function automatic logic map_ok(input logic [31:0] m);
    logic ok;
    ok = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (int'(m[4*k +: 4]) >= N) ok = 1'b0;
    end
    return ok;
  endfunction

  // settings decode
  logic [7:0] reg_off;
  logic       wr_rx, wr_tx, wr_ctrl, wr_rbsel;
  logic       apply, clr;

  assign reg_off  = set_addr - SR_BASE;
  assign wr_rx    = set_stb && (reg_off == 8'd0);
  assign wr_tx    = set_stb && (reg_off == 8'd1);
  assign wr_ctrl  = set_stb && (reg_off == 8'd2);
  assign wr_rbsel = set_stb && (reg_off == 8'd3);
  assign apply    = wr_ctrl && set_data[0];
  assign clr      = wr_ctrl && set_data[2];

  state_e      state_q, state_d;
  logic [31:0] shd_rx_q, shd_rx_d, shd_tx_q, shd_tx_d;
  logic [31:0] pend_rx_q, pend_rx_d, pend_tx_q, pend_tx_d;
  logic [31:0] act_rx_q, act_rx_d, act_tx_q, act_tx_d;
  logic        pend_force_q, pend_force_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  apply_cnt_q, apply_cnt_d;
  logic [1:0]  rb_sel_q, rb_sel_d;
  logic        err_q, err_d, ovr_q, ovr_d, lost_q, lost_d;
  logic        err_set, ovr_set, lost_ev;
  logic [1:0]  lock_m_q, lock_s_q, seen_q, seen_d;
  logic        busy_q, busy_d, blank;
  logic [31:0] rb_q, rb_d;
  logic        shadow_ok;

  logic [N-1:0]    rx_stb_q, rx_stb_d, tx_stb_q, tx_stb_d;
  logic [N*DW-1:0] rx_data_q, rx_data_d, tx_data_q, tx_data_d;
  logic [N*32-1:0] gpio_q, gpio_d;

  assign shadow_ok = map_ok(shd_rx_q) && map_ok(shd_tx_q);

  // shadow registers and readback select
  always_comb begin
    shd_rx_d = shd_rx_q;
    shd_tx_d = shd_tx_q;
    rb_sel_d = rb_sel_q;
    if (wr_rx)    shd_rx_d = set_data;
    if (wr_tx)    shd_tx_d = set_data;
    if (wr_rbsel) rb_sel_d = set_data[1:0];
  end

  // next-state and switch bookkeeping
  always_comb begin
    state_d      = state_q;
    pend_rx_d    = pend_rx_q;
    pend_tx_d    = pend_tx_q;
    pend_force_d = pend_force_q;
    act_rx_d     = act_rx_q;
    act_tx_d     = act_tx_q;
    cnt_d        = cnt_q;
    apply_cnt_d  = apply_cnt_q;
    err_set      = 1'b0;
    ovr_set      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (apply) begin
          if (!shadow_ok) begin
            err_set = 1'b1;
          end else begin
            pend_rx_d    = shd_rx_q;
            pend_tx_d    = shd_tx_q;
            pend_force_d = set_data[1];
            state_d      = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (apply) begin
          if (!shadow_ok) begin
            err_set = 1'b1;
          end else begin
            pend_rx_d    = shd_rx_q;
            pend_tx_d    = shd_tx_q;
            pend_force_d = set_data[1];
          end
        end
        if (pend_force_q || !(|{rx_running, tx_running})) begin
          state_d = ST_BLANK;
          cnt_d   = 8'(BLANK_CYCLES);
        end
      end
      ST_BLANK: begin
        if (apply) ovr_set = 1'b1;
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          act_rx_d    = pend_rx_q;
          act_tx_d    = pend_tx_q;
          apply_cnt_d = apply_cnt_q + 8'd1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // outputs derived from the upcoming state so registered
  // strobes are low exactly during the BLANK cycles
  always_comb begin
    busy_d = (state_d != ST_IDLE);
    blank  = (state_d == ST_BLANK);
  end

  // sticky status; a new event beats a same-cycle clear
  always_comb begin
    err_d   = err_set ? 1'b1 : (clr ? 1'b0 : err_q);
    ovr_d   = ovr_set ? 1'b1 : (clr ? 1'b0 : ovr_q);
    lost_ev = |(seen_q & ~lock_s_q);
    lost_d  = lost_ev ? 1'b1 : (clr ? 1'b0 : lost_q);
    seen_d  = (clr ? 2'b00 : seen_q) | lock_s_q;
  end

  // mapped datapath
  always_comb begin
    int ri;
    int ti;
    ri        = 0;
    ti        = 0;
    rx_data_d = '0;
    rx_stb_d  = '0;
    tx_data_d = '0;
    tx_stb_d  = '0;
    gpio_d    = '0;
    for (int k = 0; k < N; k++) begin
      ri = int'(act_rx_q[4*k +: 4]);
      ti = int'(act_tx_q[4*k +: 4]);
      if (ri < N) begin
        rx_data_d[k*DW +: DW] = rx_data_in[ri*DW +: DW];
        rx_stb_d[k]           = rx_stb_in[ri];
      end
      if (ti < N) begin
        tx_data_d[k*DW +: DW] = tx_data_in[ti*DW +: DW];
        tx_stb_d[ti]          = tx_stb_d[ti] | tx_stb_in[k];
        gpio_d[k*32 +: 32]    = db_gpio_in[ti*32 +: 32];
      end
    end
    if (blank) begin
      rx_stb_d  = '0;
      tx_stb_d  = '0;
      tx_data_d = '0;
    end
  end

  // readback mux
  always_comb begin
    rb_d = '0;
    unique case (rb_sel_q)
      2'd0: rb_d = act_rx_q;
      2'd1: rb_d = act_tx_q;
      2'd2: rb_d = {16'd0, apply_cnt_q, 2'b00, lock_s_q,
                    lost_q, ovr_q, err_q, busy_q};
      default: rb_d = {24'd0, 8'(N)};
    endcase
  end

  always_ff @(posedge radio_clk or negedge radio_rst_n) begin
    if (!radio_rst_n) begin
      state_q      <= ST_IDLE;
      shd_rx_q     <= ident_map();
      shd_tx_q     <= ident_map();
      pend_rx_q    <= ident_map();
      pend_tx_q    <= ident_map();
      act_rx_q     <= ident_map();
      act_tx_q     <= ident_map();
      pend_force_q <= 1'b0;
      cnt_q        <= '0;
      apply_cnt_q  <= '0;
      rb_sel_q     <= '0;
      err_q        <= 1'b0;
      ovr_q        <= 1'b0;
      lost_q       <= 1'b0;
      seen_q       <= '0;
      lock_m_q     <= '0;
      lock_s_q     <= '0;
      busy_q       <= 1'b0;
      rb_q         <= '0;
      rx_stb_q     <= '0;
      rx_data_q    <= '0;
      tx_stb_q     <= '0;
      tx_data_q    <= '0;
      gpio_q       <= '0;
    end else begin
      state_q      <= state_d;
      shd_rx_q     <= shd_rx_d;
      shd_tx_q     <= shd_tx_d;
      pend_rx_q    <= pend_rx_d;
      pend_tx_q    <= pend_tx_d;
      act_rx_q     <= act_rx_d;
      act_tx_q     <= act_tx_d;
      pend_force_q <= pend_force_d;
      cnt_q        <= cnt_d;
      apply_cnt_q  <= apply_cnt_d;
      rb_sel_q     <= rb_sel_d;
      err_q        <= err_d;
      ovr_q        <= ovr_d;
      lost_q       <= lost_d;
      seen_q       <= seen_d;
      lock_m_q     <= lock_signals;
      lock_s_q     <= lock_m_q;
      busy_q       <= busy_d;
      rb_q         <= rb_d;
      rx_stb_q     <= rx_stb_d;
      rx_data_q    <= rx_data_d;
      tx_stb_q     <= tx_stb_d;
      tx_data_q    <= tx_data_d;
      gpio_q       <= gpio_d;
    end
  end

  assign rb_data     = rb_q;
  assign map_busy    = busy_q;
  assign rx_stb_out  = rx_stb_q;
  assign rx_data_out = rx_data_q;
  assign tx_stb_out  = tx_stb_q;
  assign tx_data_out = tx_data_q;
  assign db_gpio_out = gpio_q;

endmodule

// File: tb/tb_radio_chan_map.sv
// tb_radio_chan_map: scoreboard bench for radio_chan_map (N=2, DW=32).
// Random traffic under a known map plus directed switch/status sequences.
module tb_radio_chan_map;

  localparam int N  = 2;
  localparam int DW = 32;
  localparam int BC = 2;

  logic            radio_clk = 1'b0;
  logic            radio_rst_n = 1'b0;
  logic            set_stb = 1'b0;
  logic [7:0]      set_addr = '0;
  logic [31:0]     set_data = '0;
  logic [31:0]     rb_data;
  logic [N-1:0]    rx_stb_in = '0;
  logic [N*DW-1:0] rx_data_in = '0;
  logic [N-1:0]    rx_stb_out;
  logic [N*DW-1:0] rx_data_out;
  logic [N-1:0]    tx_stb_in = '0;
  logic [N-1:0]    tx_stb_out;
  logic [N*DW-1:0] tx_data_in = '0;
  logic [N*DW-1:0] tx_data_out;
  logic [N*32-1:0] db_gpio_in = '0;
  logic [N*32-1:0] db_gpio_out;
  logic [N-1:0]    rx_running = '0;
  logic [N-1:0]    tx_running = '0;
  logic [1:0]      lock_signals = '0;
  logic            map_busy;

  radio_chan_map #(
    .NUM_CHANNELS(N),
    .DATA_WIDTH(DW),
    .SR_BASE(8'd0),
    .BLANK_CYCLES(BC)
  ) dut (
    .radio_clk(radio_clk),
    .radio_rst_n(radio_rst_n),
    .set_stb(set_stb),
    .set_addr(set_addr),
    .set_data(set_data),
    .rb_data(rb_data),
    .rx_stb_in(rx_stb_in),
    .rx_data_in(rx_data_in),
    .rx_stb_out(rx_stb_out),
    .rx_data_out(rx_data_out),
    .tx_stb_in(tx_stb_in),
    .tx_stb_out(tx_stb_out),
    .tx_data_in(tx_data_in),
    .tx_data_out(tx_data_out),
    .db_gpio_in(db_gpio_in),
    .db_gpio_out(db_gpio_out),
    .rx_running(rx_running),
    .tx_running(tx_running),
    .lock_signals(lock_signals),
    .map_busy(map_busy)
  );

  always #5 radio_clk = ~radio_clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [N*DW-1:0] rxd;
    logic [N-1:0]    rxs;
    logic [N*DW-1:0] txd;
    logic [N-1:0]    txs;
    logic [N*32-1:0] gp;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] mrx = 32'h10;
  logic [31:0] mtx = 32'h10;

  function automatic exp_t predict();
    exp_t e;
    int   s;
    e.rxd = '0;
    e.rxs = '0;
    e.txd = '0;
    e.txs = '0;
    e.gp  = '0;
    for (int k = 0; k < N; k++) begin
      s = int'(mrx[4*k +: 4]);
      e.rxd[k*DW +: DW] = rx_data_in[s*DW +: DW];
      e.rxs[k] = rx_stb_in[s];
      s = int'(mtx[4*k +: 4]);
      e.txd[k*DW +: DW] = tx_data_in[s*DW +: DW];
      e.txs[s] = e.txs[s] | tx_stb_in[k];
      e.gp[k*32 +: 32] = db_gpio_in[s*32 +: 32];
    end
    return e;
  endfunction

  task automatic traffic(input int n);
    exp_t e;
    for (int i = 0; i <= n; i++) begin
      @(negedge radio_clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("rx_data", rx_data_out, e.rxd);
        check("rx_stb", rx_stb_out, e.rxs);
        check("tx_data", tx_data_out, e.txd);
        check("tx_stb", tx_stb_out, e.txs);
        check("gpio", db_gpio_out, e.gp);
      end
      if (i < n) begin
        rx_data_in = {$urandom, $urandom};
        tx_data_in = {$urandom, $urandom};
        db_gpio_in = {$urandom, $urandom};
        rx_stb_in  = 2'($urandom);
        tx_stb_in  = 2'($urandom);
        sbq.push_back(predict());
      end
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    set_addr = a;
    set_data = d;
    set_stb  = 1'b1;
    @(negedge radio_clk);
    set_stb  = 1'b0;
  endtask

  task automatic rd(input logic [1:0] sel, input logic [31:0] exp,
                    input string tag);
    wr(8'd3, {30'd0, sel});
    @(negedge radio_clk);
    check(tag, rb_data, exp);
  endtask

  task automatic wait_idle(input int bound, input string tag);
    for (int i = 0; i < bound; i++) begin
      if (!map_busy) break;
      @(negedge radio_clk);
    end
    check(tag, map_busy, 1'b0);
  endtask

  initial begin
    rx_data_in = {32'hBBBB_0001, 32'hAAAA_0000};
    rx_stb_in  = 2'b11;
    repeat (3) @(negedge radio_clk);
    check("rst_rb", rb_data, 32'h0);
    check("rst_rx_data", rx_data_out, 64'h0);
    check("rst_rx_stb", rx_stb_out, 2'b00);
    check("rst_busy", map_busy, 1'b0);
    radio_rst_n = 1'b1;
    @(negedge radio_clk);
    check("rb_rxmap_id", rb_data, 32'h10);
    check("id_rx_data", rx_data_out, {32'hBBBB_0001, 32'hAAAA_0000});
    check("id_rx_stb", rx_stb_out, 2'b11);
    rd(2'd1, 32'h10, "rb_txmap_id");
    rd(2'd3, 32'h2, "rb_nch");
    traffic(8);

    // idle swap, cycle-exact blanking
    rx_data_in = {32'hBBBB_0001, 32'hAAAA_0000};
    rx_stb_in  = 2'b11;
    tx_stb_in  = 2'b01;
    tx_data_in = {32'h2222_2222, 32'h1111_1111};
    wr(8'd0, 32'h01);
    wr(8'd1, 32'h01);
    wr(8'd2, 32'h1);
    check("swap_wait_busy", map_busy, 1'b1);
    @(negedge radio_clk);
    check("blank1_rx_stb", rx_stb_out, 2'b00);
    check("blank1_tx_stb", tx_stb_out, 2'b00);
    check("blank1_tx_data", tx_data_out, 64'h0);
    @(negedge radio_clk);
    check("blank2_rx_stb", rx_stb_out, 2'b00);
    check("blank2_tx_data", tx_data_out, 64'h0);
    @(negedge radio_clk);
    check("old_map_rx", rx_data_out, {32'hBBBB_0001, 32'hAAAA_0000});
    check("old_map_stb", rx_stb_out, 2'b11);
    @(negedge radio_clk);
    check("new_map_rx", rx_data_out, {32'hAAAA_0000, 32'hBBBB_0001});
    check("new_map_tx_stb", tx_stb_out, 2'b10);
    check("swap_idle", map_busy, 1'b0);
    mrx = 32'h01;
    mtx = 32'h01;
    traffic(8);
    rd(2'd2, 32'h100, "status_cnt1");

    // hold while running
    rx_running = 2'b01;
    wr(8'd0, 32'h10);
    wr(8'd1, 32'h10);
    wr(8'd2, 32'h1);
    traffic(6);
    check("hold_busy", map_busy, 1'b1);
    rx_running = 2'b00;
    wait_idle(10, "hold_done");
    mrx = 32'h10;
    mtx = 32'h10;
    traffic(6);

    // forced switch while running
    tx_running = 2'b10;
    wr(8'd0, 32'h01);
    wr(8'd1, 32'h01);
    wr(8'd2, 32'h3);
    wait_idle(BC + 4, "force_done");
    mrx = 32'h01;
    mtx = 32'h01;
    traffic(6);
    tx_running = 2'b00;
    rd(2'd2, 32'h300, "status_cnt3");

    // invalid map
    wr(8'd0, 32'h02);
    wr(8'd2, 32'h1);
    check("inv_not_busy", map_busy, 1'b0);
    rd(2'd2, 32'h302, "status_err");
    rd(2'd0, 32'h01, "inv_map_kept");
    wr(8'd2, 32'h4);
    rd(2'd2, 32'h300, "err_clear");
    traffic(4);

    // apply during blank
    wr(8'd0, 32'h10);
    wr(8'd1, 32'h10);
    wr(8'd2, 32'h1);
    @(negedge radio_clk);
    wr(8'd2, 32'h1);
    wait_idle(10, "ovr_done");
    repeat (3) @(negedge radio_clk);
    check("ovr_no_rerun", map_busy, 1'b0);
    rd(2'd2, 32'h404, "status_ovr");
    rd(2'd0, 32'h10, "ovr_map");
    mrx = 32'h10;
    mtx = 32'h10;
    traffic(4);

    // lock monitoring
    wr(8'd2, 32'h4);
    lock_signals = 2'b11;
    repeat (4) @(negedge radio_clk);
    rd(2'd2, 32'h430, "lock_synced");
    lock_signals = 2'b10;
    for (int i = 0; i < 6; i++) begin
      @(negedge radio_clk);
      if (rb_data[3]) break;
    end
    check("lock_lost", rb_data[3], 1'b1);
    lock_signals = 2'b11;
    repeat (4) @(negedge radio_clk);
    rd(2'd2, 32'h438, "lost_sticky");
    wr(8'd2, 32'h4);
    rd(2'd2, 32'h430, "lost_clear");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
